// File: rtl/nzcv_rename_unit.sv
// NZCV flag rename unit: architectural flags, youngest-setter rename,
// CDB capture with bypass, commit retirement and flush recovery.
module nzcv_rename_unit #(
    parameter int TAG_WIDTH    = 4,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_disp_valid,
    input  logic                 in_disp_sets_flags,
    input  logic [TAG_WIDTH-1:0] in_disp_tag,
    output logic                 out_nzcv_ready,
    output logic [3:0]           out_nzcv,
    output logic [TAG_WIDTH-1:0] out_nzcv_tag,
    output logic                 out_disp_stall,
    input  logic                 in_cdb_valid,
    input  logic                 in_cdb_sets_flags,
    input  logic [TAG_WIDTH-1:0] in_cdb_tag,
    input  logic [3:0]           in_cdb_nzcv,
    input  logic                 in_commit_valid,
    input  logic                 in_commit_sets_flags,
    input  logic [TAG_WIDTH-1:0] in_commit_tag,
    input  logic [3:0]           in_commit_nzcv,
    input  logic                 in_flush,
    output logic [3:0]           out_arch_nzcv
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {
        CLEAN,
        PENDING,
        RESOLVED
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           arch_q, arch_d;
    logic [3:0]           spec_q, spec_d;
    logic [TAG_WIDTH-1:0] pend_q, pend_d;
    logic [CW-1:0]        count_q, count_d;

    logic disp_set;
    logic cdb_hit;
    logic commit_set;
    logic cnt_inc;
    logic cnt_dec;

    assign out_disp_stall = (count_q == CW'(MAX_INFLIGHT));
    assign disp_set   = in_disp_valid & in_disp_sets_flags
                      & ~out_disp_stall;
    assign cdb_hit    = (state_q == PENDING) & in_cdb_valid
                      & in_cdb_sets_flags & (in_cdb_tag == pend_q);
    assign commit_set = in_commit_valid & in_commit_sets_flags;
    assign cnt_inc    = disp_set;
    assign cnt_dec    = commit_set & (count_q != '0);
    assign out_arch_nzcv = arch_q;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= CLEAN;
            arch_q  <= '0;
            spec_q  <= '0;
            pend_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            arch_q  <= arch_d;
            spec_q  <= spec_d;
            pend_q  <= pend_d;
            count_q <= count_d;
        end
    end

    // Read path sees registered state; only the CDB bypass is same-cycle.
    always_comb begin
        out_nzcv_ready = 1'b1;
        out_nzcv       = arch_q;
        out_nzcv_tag   = pend_q;
        case (state_q)
            RESOLVED: out_nzcv = spec_q;
            PENDING: begin
                if (cdb_hit) begin
                    out_nzcv = in_cdb_nzcv;
                end else begin
                    out_nzcv_ready = 1'b0;
                    out_nzcv       = spec_q;
                end
            end
            default: out_nzcv = arch_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        arch_d  = commit_set ? in_commit_nzcv : arch_q;
        spec_d  = spec_q;
        pend_d  = pend_q;
        count_d = count_q;
        if (in_flush) begin
            state_d = CLEAN;
            count_d = '0;
            spec_d  = arch_d;
        end else begin
            if (disp_set) begin
                state_d = PENDING;
                pend_d  = in_disp_tag;
            end else if (cdb_hit) begin
                state_d = RESOLVED;
                spec_d  = in_cdb_nzcv;
            end
            // Only the youngest setter retiring leaves no rename behind.
            if (commit_set && state_q != CLEAN && !disp_set
                && in_commit_tag == pend_q) begin
                state_d = CLEAN;
            end
            if (cnt_inc && !cnt_dec) begin
                count_d = count_q + CW'(1);
            end else if (cnt_dec && !cnt_inc) begin
                count_d = count_q - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_nzcv_rename_unit.sv
// Directed bench for nzcv_rename_unit with a per-cycle behavioural
// model of the youngest flag producer and literal checkpoints.
module tb_nzcv_rename_unit;

    localparam int TW  = 4;
    localparam int MAX = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          disp_valid, disp_sets;
    logic [TW-1:0] disp_tag;
    logic          nzcv_ready;
    logic [3:0]    nzcv;
    logic [TW-1:0] nzcv_tag;
    logic          stall;
    logic          cdb_valid, cdb_sets;
    logic [TW-1:0] cdb_tag;
    logic [3:0]    cdb_nzcv;
    logic          cm_valid, cm_sets;
    logic [TW-1:0] cm_tag;
    logic [3:0]    cm_nzcv;
    logic          flush;
    logic [3:0]    arch_nzcv;

    int n_cmp  = 0;
    int n_fail = 0;

    nzcv_rename_unit #(.TAG_WIDTH(TW), .MAX_INFLIGHT(MAX)) dut (
        .in_clk              (clk),
        .in_rst              (rst),
        .in_disp_valid       (disp_valid),
        .in_disp_sets_flags  (disp_sets),
        .in_disp_tag         (disp_tag),
        .out_nzcv_ready      (nzcv_ready),
        .out_nzcv            (nzcv),
        .out_nzcv_tag        (nzcv_tag),
        .out_disp_stall      (stall),
        .in_cdb_valid        (cdb_valid),
        .in_cdb_sets_flags   (cdb_sets),
        .in_cdb_tag          (cdb_tag),
        .in_cdb_nzcv         (cdb_nzcv),
        .in_commit_valid     (cm_valid),
        .in_commit_sets_flags(cm_sets),
        .in_commit_tag       (cm_tag),
        .in_commit_nzcv      (cm_nzcv),
        .in_flush            (flush),
        .out_arch_nzcv       (arch_nzcv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: is there an uncommitted youngest setter, and is its value known
    bit         m_init = 0;
    bit         m_young;
    bit         m_known;
    logic [3:0] m_tag;
    logic [3:0] m_val;
    logic [3:0] m_arch;
    int         m_count;
    logic [3:0] m_na;
    bit         m_acc;
    bit         m_cm;

    always @(posedge clk) begin
        if (rst) begin
            m_init  = 1;
            m_young = 0;
            m_known = 0;
            m_tag   = 0;
            m_val   = 0;
            m_arch  = 0;
            m_count = 0;
        end else if (m_init) begin
            m_cm  = cm_valid && cm_sets;
            m_na  = m_cm ? cm_nzcv : m_arch;
            m_acc = disp_valid && disp_sets && (m_count < MAX);
            if (flush) begin
                m_young = 0;
                m_count = 0;
            end else begin
                if (m_acc) begin
                    m_young = 1;
                    m_known = 0;
                    m_tag   = disp_tag;
                end else if (m_young && !m_known && cdb_valid
                             && cdb_sets && cdb_tag == m_tag) begin
                    m_known = 1;
                    m_val   = cdb_nzcv;
                end
                if (m_cm && m_young && !m_acc && cm_tag == m_tag)
                    m_young = 0;
                if (m_acc && !(m_cm && m_count > 0))
                    m_count = m_count + 1;
                else if (!m_acc && m_cm && m_count > 0)
                    m_count = m_count - 1;
            end
            m_arch = m_na;
        end
    end

    bit         e_rdy;
    logic [3:0] e_val;

    always @(negedge clk) begin
        if (m_init && !rst) begin
            if (!m_young) begin
                e_rdy = 1;
                e_val = m_arch;
            end else if (m_known) begin
                e_rdy = 1;
                e_val = m_val;
            end else if (cdb_valid && cdb_sets && cdb_tag == m_tag) begin
                e_rdy = 1;
                e_val = cdb_nzcv;
            end else begin
                e_rdy = 0;
                e_val = 0;
            end
            chk("mdl_ready", int'(nzcv_ready), int'(e_rdy));
            if (e_rdy)
                chk("mdl_nzcv", int'(nzcv), int'(e_val));
            else
                chk("mdl_tag", int'(nzcv_tag), int'(m_tag));
            chk("mdl_stall", int'(stall), int'(m_count == MAX));
            chk("mdl_arch", int'(arch_nzcv), int'(m_arch));
        end
    end

    task automatic idle();
        disp_valid = 0; disp_sets = 0; disp_tag = 0;
        cdb_valid  = 0; cdb_sets  = 0; cdb_tag  = 0; cdb_nzcv = 0;
        cm_valid   = 0; cm_sets   = 0; cm_tag   = 0; cm_nzcv  = 0;
        flush      = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [3:0] t);
        disp_valid = 1; disp_sets = 1; disp_tag = t;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [3:0] v);
        cdb_valid = 1; cdb_sets = 1; cdb_tag = t; cdb_nzcv = v;
    endtask

    task automatic commit(input logic [3:0] t, input logic [3:0] v);
        cm_valid = 1; cm_sets = 1; cm_tag = t; cm_nzcv = v;
    endtask

    // Literal checkpoint taken mid-cycle after inputs settle
    task automatic lit(input string name, input bit rdy,
                       input int val, input int tag,
                       input int arch, input bit stl);
        #2;
        chk({name, "_ready"}, int'(nzcv_ready), int'(rdy));
        if (rdy) chk({name, "_nzcv"}, int'(nzcv), val);
        else     chk({name, "_tag"}, int'(nzcv_tag), tag);
        chk({name, "_arch"}, int'(arch_nzcv), arch);
        chk({name, "_stall"}, int'(stall), int'(stl));
    endtask

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
        lit("reset", 1, 0, 0, 0, 0);

        disp(3); tick(); idle();
        lit("renamed", 0, 0, 3, 0, 0);
        cdb(3, 4'b0100);
        lit("bypass", 1, 4'b0100, 0, 0, 0);
        tick(); idle();
        lit("resolved", 1, 4'b0100, 0, 0, 0);
        commit(3, 4'b0100); tick(); idle();
        lit("commit", 1, 4'b0100, 0, 4'b0100, 0);

        disp(2); tick(); idle();
        disp(5); tick(); idle();
        commit(2, 4'b0001); tick(); idle();
        lit("older_cm", 0, 0, 5, 4'b0001, 0);

        disp(7); cdb(5, 4'b1111); tick(); idle();
        lit("simul", 0, 0, 7, 4'b0001, 0);
        cdb(5, 4'b1111);
        lit("stale_cdb", 0, 0, 7, 4'b0001, 0);
        tick(); idle();
        lit("stale_after", 0, 0, 7, 4'b0001, 0);

        commit(5, 4'b1000); tick(); idle();
        lit("arch1000", 0, 0, 7, 4'b1000, 0);
        disp(4); tick(); idle();
        flush = 1; commit(2, 4'b0010); disp(9); cdb(4, 4'b1110);
        tick(); idle();
        lit("flush", 1, 4'b0010, 0, 4'b0010, 0);

        for (int i = 0; i < MAX; i++) begin
            disp(4'(i)); tick(); idle();
        end
        lit("full", 0, 0, 7, 4'b0010, 1);
        disp(9); tick(); idle();
        lit("ninth", 0, 0, 7, 4'b0010, 1);
        commit(0, 4'b0011); tick(); idle();
        lit("unstall", 0, 0, 7, 4'b0011, 0);
        commit(1, 4'b0011); disp(10); tick(); idle();
        lit("cm_disp7", 0, 0, 10, 4'b0011, 0);
        disp(11); tick(); idle();
        lit("refill", 0, 0, 11, 4'b0011, 1);
        commit(11, 4'b0101); tick(); idle();
        lit("young_cm", 1, 4'b0101, 0, 4'b0101, 0);

        flush = 1; tick(); idle();
        disp(6); tick(); idle();
        cdb_valid = 1; cdb_sets = 0; cdb_tag = 6; cdb_nzcv = 4'b1001;
        lit("noflag_cdb", 0, 0, 6, 4'b0101, 0);
        tick(); idle();
        cdb(6, 4'b1001); tick(); idle();
        lit("res6", 1, 4'b1001, 0, 4'b0101, 0);
        disp(1); disp_sets = 0; tick(); idle();
        lit("nonsetter", 1, 4'b1001, 0, 4'b0101, 0);

        disp(12); tick(); idle();
        rst = 1; tick(); rst = 0;
        lit("midreset", 1, 0, 0, 0, 0);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
